// File: rtl/sca_blk_alloc.sv
// rtl/sca_blk_alloc.sv - SCA capacitor block allocator with free list, readout queue and release tracking
//
// Purpose: keeps the free list of SCA blocks, hands a new write block to the
// write controller on each block boundary when a capture occurred, queues the
// captured blocks for the digitizer and takes blocks back after digitization.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   CAPT, CAPT_LCT      capture pulse and its LCT tag
//   NBSEL               block-boundary pulse
//   DIG_RDY             digitizer accepts queue head
//   DIG_DONE, DONE_BLK  digitization finished for DONE_BLK
//   WBLK                current write block
//   DIG_VLD/BLK/LCT     readout queue head
//   NFREE               free list occupancy
//   SCAFULL, LSCAFULL   free list empty / at or below low mark
//   OVFL, OVFL_CNT      dropped-capture pulse and saturating count
module sca_blk_alloc #(
   parameter int NBLK    = 12,
   parameter int LOWMARK = 2,
   parameter int TMR     = 0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CAPT,
   input  logic       CAPT_LCT,
   input  logic       NBSEL,
   input  logic       DIG_RDY,
   input  logic       DIG_DONE,
   input  logic [3:0] DONE_BLK,
   output logic [3:0] WBLK,
   output logic       DIG_VLD,
   output logic [3:0] DIG_BLK,
   output logic       DIG_LCT,
   output logic [4:0] NFREE,
   output logic       SCAFULL,
   output logic       LSCAFULL,
   output logic       OVFL,
   output logic [7:0] OVFL_CNT
);

   localparam logic [3:0] LAST   = 4'(NBLK - 1);
   localparam logic [4:0] NBLK_W = 5'(NBLK);

   // Storage is sized for the maximum of 16 blocks; pointers wrap at NBLK.
   logic [3:0]  free_mem [0:15];
   logic [3:0]  free_rd, free_wr;
   logic [4:0]  nfree;

   logic [3:0]  q_blk [0:15];
   logic        q_tag [0:15];
   logic [3:0]  q_rd, q_wr;
   logic [4:0]  q_cnt;
   logic        dig_vld;

   logic [15:0] dig_map;
   logic        capt_pend, capt_tag;
   logic        ovfl;

   logic        eff_capt, eff_tag, alloc, drop, rel, pop;
   logic [4:0]  nfree_nxt, q_cnt_nxt;
   logic [7:0]  ovfl_vote, ovfl_inc;

   function automatic logic [3:0] ptr_inc(input logic [3:0] p);
      return (p == LAST) ? 4'd0 : p + 4'd1;
   endfunction

   // A CAPT in the boundary cycle itself is the latest one, so its tag wins.
   assign eff_capt = NBSEL & (capt_pend | CAPT);
   assign eff_tag  = CAPT ? CAPT_LCT : capt_tag;
   assign alloc    = eff_capt & (nfree != 5'd0);
   assign drop     = eff_capt & (nfree == 5'd0);
   // Only blocks currently being digitized may be released.
   assign rel      = DIG_DONE & ({1'b0, DONE_BLK} < NBLK_W) & dig_map[DONE_BLK];
   assign pop      = dig_vld & DIG_RDY;

   always_comb begin
      nfree_nxt = nfree;
      if (rel && !alloc)
         nfree_nxt = nfree + 5'd1;
      else if (alloc && !rel)
         nfree_nxt = nfree - 5'd1;
      q_cnt_nxt = q_cnt;
      if (alloc && !pop)
         q_cnt_nxt = q_cnt + 5'd1;
      else if (pop && !alloc)
         q_cnt_nxt = q_cnt - 5'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 16; i++)
            free_mem[i] <= (i < NBLK - 1) ? 4'(i + 1) : 4'd0;
         free_rd   <= 4'd0;
         free_wr   <= LAST;
         nfree     <= 5'(NBLK - 1);
         SCAFULL   <= 1'b0;
         LSCAFULL  <= (NBLK - 1 <= LOWMARK);
         WBLK      <= 4'd0;
         q_rd      <= 4'd0;
         q_wr      <= 4'd0;
         q_cnt     <= 5'd0;
         dig_vld   <= 1'b0;
         dig_map   <= 16'd0;
         capt_pend <= 1'b0;
         capt_tag  <= 1'b0;
         ovfl      <= 1'b0;
      end else begin
         if (NBSEL) begin
            capt_pend <= 1'b0;
            capt_tag  <= 1'b0;
         end else if (CAPT) begin
            capt_pend <= 1'b1;
            capt_tag  <= CAPT_LCT;
         end

         if (alloc) begin
            WBLK    <= free_mem[free_rd];
            free_rd <= ptr_inc(free_rd);
            q_wr    <= ptr_inc(q_wr);
         end
         if (rel) begin
            free_mem[free_wr] <= DONE_BLK;
            free_wr           <= ptr_inc(free_wr);
         end
         if (pop)
            q_rd <= ptr_inc(q_rd);

         // Popped and released blocks are always distinct: a popped block's bit
         // is not yet set, so it cannot pass the release check in that cycle.
         if (pop)
            dig_map[q_blk[q_rd]] <= 1'b1;
         if (rel)
            dig_map[DONE_BLK] <= 1'b0;

         nfree    <= nfree_nxt;
         SCAFULL  <= (nfree_nxt == 5'd0);
         LSCAFULL <= (int'(nfree_nxt) <= LOWMARK);
         q_cnt    <= q_cnt_nxt;
         dig_vld  <= (q_cnt_nxt != 5'd0);
         ovfl     <= drop;
      end
   end

   // Queue payload needs no reset: it is only observed while valid.
   always_ff @(posedge CLK) begin
      if (alloc) begin
         q_blk[q_wr] <= WBLK;
         q_tag[q_wr] <= eff_tag;
      end
   end

   assign ovfl_inc = (ovfl_vote == 8'hFF) ? 8'hFF : ovfl_vote + 8'd1;

   generate
      if (TMR != 0) begin : g_tmr
         logic [7:0] cnt_a, cnt_b, cnt_c;
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               cnt_a <= 8'd0;
               cnt_b <= 8'd0;
               cnt_c <= 8'd0;
            end else if (drop) begin
               cnt_a <= ovfl_inc;
               cnt_b <= ovfl_inc;
               cnt_c <= ovfl_inc;
            end else begin
               // Continuous scrubbing: each copy is rewritten with the vote.
               cnt_a <= ovfl_vote;
               cnt_b <= ovfl_vote;
               cnt_c <= ovfl_vote;
            end
         end
         assign ovfl_vote = (cnt_a & cnt_b) | (cnt_a & cnt_c) | (cnt_b & cnt_c);
      end else begin : g_simplex
         logic [7:0] cnt;
         always_ff @(posedge CLK or posedge RST) begin
            if (RST)
               cnt <= 8'd0;
            else if (drop)
               cnt <= ovfl_inc;
         end
         assign ovfl_vote = cnt;
      end
   endgenerate

   assign NFREE    = nfree;
   assign DIG_VLD  = dig_vld;
   assign DIG_BLK  = dig_vld ? q_blk[q_rd] : 4'd0;
   assign DIG_LCT  = dig_vld ? q_tag[q_rd] : 1'b0;
   assign OVFL     = ovfl;
   assign OVFL_CNT = ovfl_vote;

endmodule

// File: doc/sca_blk_alloc.md
# sca_blk_alloc

SCA block allocator for the CFEB capture path. It keeps the free list of SCA capacitor blocks and assigns the block that the write controller fills during each 16-cycle block window. Captured blocks go into a readout queue for the digitizer, and the allocator takes each block back once digitization finishes. The SCAFULL / LSCAFULL status it produces is what the write controller consumes as its full flags.

## Interface
Parameters:
- NBLK, 12: number of SCA blocks; legal range 2..16.
- LOWMARK, 2: LSCAFULL asserts when free count ≤ LOWMARK.
- TMR, 0: triplication select, passed through to counter primitives.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; asynchronous, active-high.
- CAPT  in  1  single-cycle pulse: the current write block holds data that must be kept. It may arrive on any cycle of the window.
- CAPT_LCT  in  1  tag sampled with CAPT: 1 = LCT capture, 0 = no-LCT capture.
- NBSEL  in  1  block-boundary pulse, one per 16-cycle window.
- DIG_RDY  in  1  digitizer is ready to accept the queue head.
- DIG_DONE  in  1  single-cycle pulse: digitization of DONE_BLK is finished.
- DONE_BLK  in  4  block being released.
- WBLK  out  4  current write block.
- DIG_VLD  out  1  the queue head is valid.
- DIG_BLK  out  4  block number at the queue head.
- DIG_LCT  out  1  tag of the queue head.
- NFREE  out  5  number of blocks in the free list.
- SCAFULL  out  1  NFREE == 0.
- LSCAFULL  out  1  NFREE ≤ LOWMARK.
- OVFL  out  1  single-cycle pulse when a capture is dropped.
- OVFL_CNT  out  8  count of dropped captures; saturates.

## Operation
- Every block is in exactly one state: write, free, queued, or digitizing. Invariant: 1 + NFREE + queue occupancy + digitizing count == NBLK.
- Free list is a circular FIFO of depth NBLK. Readout queue is a circular FIFO of depth NBLK holding {block, tag}. A per-block digitizing bitmap tracks blocks in the digitizing state.
- Capture latch: `capt_pend` and `capt_tag` are set by CAPT. A later CAPT in the same window overwrites the tag. Both are cleared on NBSEL.
- On NBSEL, the effective capture is `capt_pend | CAPT` (same-cycle CAPT counts).
  - Effective capture with NFREE > 0: enqueue {WBLK, tag}, pop the free head into WBLK, decrement NFREE.
  - Effective capture with NFREE == 0: keep WBLK (it is overwritten). Pulse OVFL and increment OVFL_CNT; OVFL_CNT saturates at 255.
  - No capture: WBLK is unchanged and is reused.
- Digitizer handshake: the transfer happens on a cycle with DIG_VLD & DIG_RDY. The head is popped and its block bit is set in the digitizing bitmap. DIG_BLK and DIG_LCT stay stable while DIG_VLD=1 and DIG_RDY=0.
- Release on DIG_DONE:
  - If the bitmap bit for DONE_BLK is set: clear the bit, push DONE_BLK onto the free list, increment NFREE.
  - If DONE_BLK ≥ NBLK or its bit is clear: ignore the release (no state change).
- Simultaneous release and allocation: both happen and NFREE is unchanged. There is no bypass: a block released on the NBSEL cycle is not available to that NBSEL. If NFREE was 0, that capture is dropped.
- Simultaneous enqueue and pop of the queue are both performed.

## Timing
- Reset values: WBLK=0; free list holds 1..NBLK-1 in ascending order; NFREE=NBLK-1; queue empty; bitmap clear; DIG_VLD=0, DIG_BLK=0, DIG_LCT=0.
- Reset values, continued: SCAFULL=0; LSCAFULL=(NBLK-1 ≤ LOWMARK); OVFL=0; OVFL_CNT=0; capture latch clear.
- Reset mid-operation restores all of the above on the next cycle, regardless of queue or digitizing contents.
- Allocation: WBLK takes the new value on the edge that samples NBSEL.
- Queue output: DIG_VLD rises 1 cycle after the enqueue edge, i.e. it is visible in the cycle after NBSEL. A pop on edge N shows the next head (or DIG_VLD=0) after edge N.
- Release: NFREE updates on the edge that samples DIG_DONE. The released block can be allocated by an NBSEL on the following cycle or later.
- Flags: SCAFULL and LSCAFULL are registered and always consistent with the registered NFREE in the same cycle.
- Overflow: OVFL is high for exactly the cycle after the dropping NBSEL.

## Test plan
- Reset, then idle for 50 cycles -> WBLK=0, NFREE=11, DIG_VLD=0, SCAFULL=0, LSCAFULL=0, OVFL_CNT=0.
- CAPT with CAPT_LCT=1 at window cycle 5, then NBSEL -> WBLK=1, NFREE=10. Next cycle DIG_VLD=1, DIG_BLK=0, DIG_LCT=1. With DIG_RDY=1, DIG_VLD drops. DIG_DONE with DONE_BLK=0 -> NFREE=11.
- Capture every window with DIG_RDY=0 -> NFREE counts 10..0. LSCAFULL rises when NFREE=2; SCAFULL rises when NFREE=0. The 12th capture gives an OVFL pulse, WBLK stays 11, OVFL_CNT=1.
- NFREE=0, DIG_DONE with DONE_BLK=3 on the NBSEL cycle of a capture -> capture dropped, NFREE=1. The next capturing NBSEL gives WBLK=3.
- Backpressure: hold DIG_RDY=0 for 40 cycles with 3 queued blocks -> DIG_BLK stays stable; then the blocks drain in FIFO order 0, 1, 2.
- Bogus DIG_DONE (DONE_BLK=13, then a block that is not digitizing) -> NFREE unchanged. Assert RST mid-run with a non-empty queue -> all reset values restored.
